ram_arbiter: RTL
================

# ram_arbiter

Two-requester access controller for one external `simple_dual_port_ram`, with both RAM clocks tied to `clk`. It arbitrates write and read traffic from requesters A and B independently, using round-robin on each port, and registers all RAM-side controls. It blocks any read that would collide with a write to the same address, and returns read data with a fixed 2-cycle latency and a per-requester valid strobe.

## Interface
- `WIDTH`, default 8: data word width; must match the RAM.
- `ENTRIES`, default 256: RAM depth; `AW = $clog2(ENTRIES)`.
- `clk`  in  1  clock; also drives RAM `wclk` and `rclk`.
- `rst`  in  1  reset; asynchronous, active-low.
- `a_wr_valid`, `b_wr_valid`  in  1  write request.
- `a_wr_addr`, `b_wr_addr`  in  AW  write address.
- `a_wr_data`, `b_wr_data`  in  WIDTH  write data.
- `a_wr_ready`, `b_wr_ready`  out  1  write accepted this cycle when valid&ready.
- `a_rd_valid`, `b_rd_valid`  in  1  read request.
- `a_rd_addr`, `b_rd_addr`  in  AW  read address.
- `a_rd_ready`, `b_rd_ready`  out  1  read accepted this cycle when valid&ready.
- `rd_data`  out  WIDTH  shared read-return bus; equals `ram_read_data`.
- `a_rd_data_valid`, `b_rd_data_valid`  out  1  `rd_data` belongs to this requester this cycle.
- `ram_waddr`  out  AW  drives RAM `waddr`.
- `ram_write_data`  out  WIDTH  drives RAM `write_data`.
- `ram_write_enable`  out  1  drives RAM `write_enable`.
- `ram_raddr`  out  AW  drives RAM `raddr`.
- `ram_read_data`  in  WIDTH  from RAM `read_data`.

## Operation
- Write and read ports are arbitrated independently. A write and a read may both be accepted in the same cycle.
- Each port has a priority pointer, `wr_last` / `rd_last`, holding the requester that was last granted on that port.
- A requester is eligible when its valid is high and it has no hazard.
- With one eligible requester, that requester gets ready. With two eligible, the requester that is not `*_last` gets ready. At most one ready per port per cycle.
- `*_last` updates only on a completed transfer (valid&ready), never on a request alone.
- Ready is combinational from the valids and addresses and may depend on valid. While `rst` is low, all ready outputs are 0.
- Write acceptance in cycle T loads `ram_waddr`, `ram_write_data` and `ram_write_enable=1`, which are visible in T+1. The RAM commits at the end of T+1.
- With no write accepted in T, `ram_write_enable=0` in T+1, and `ram_waddr` / `ram_write_data` hold their values.
- Read acceptance in cycle T loads `ram_raddr`, visible in T+1. Otherwise `ram_raddr` holds. The RAM samples at the end of T+1.
- Hazard: a read request has a hazard in cycle T when a write is accepted in T (either requester) and that write's address equals the read address. A hazard-blocked read gets no ready. The other requester's read may still be granted if it is eligible.
- After a stall, a read accepted in T+1 or later returns the newly written data.
- Reads are not backpressured: requesters must consume `rd_data` in the cycle their data-valid is high.
- A 2-stage shift register carries `{a_hit, b_hit}` from read acceptance to `*_rd_data_valid`.

## Timing
- Read latency: acceptance in cycle T gives `*_rd_data_valid=1` and valid `rd_data` in cycle T+2. Back-to-back accepted reads give back-to-back returns.
- Write-to-read visibility: a write accepted in T is readable by a read accepted in T+1 or later.
- Throughput: 1 write plus 1 read per cycle.
- Reset values: `ram_write_enable=0`, `ram_waddr=0`, `ram_write_data=0`, `ram_raddr=0`, `a_rd_data_valid=0`, `b_rd_data_valid=0`, all readies 0, `wr_last=B`, `rd_last=B` (A wins the first contention).
- Reset asserted mid-operation:
  - Any in-flight read returns are discarded: data-valid bits clear immediately.
  - A write already registered toward the RAM is cancelled: `ram_write_enable` clears immediately.
- After `rst` deasserts, the first acceptance can occur in the first cycle.

## Test plan
- Reset: hold `rst=0` with all valids=1 → all readies 0, `ram_write_enable=0`, data-valids 0. Release → A granted first on both ports.
- Write/read single: A writes addr 5 = 0x3C in cycle 0, then A reads addr 5 in cycle 1 → `ram_write_enable=1`, `ram_waddr=5` in cycle 1; `a_rd_data_valid=1`, `rd_data=0x3C` in cycle 3.
- Round-robin: both requesters hold `wr_valid` for 4 cycles (A addr 1..4, B addr 9..12) → grants alternate A, B, A, B; RAM sees addrs 1, 9, 2, 10.
- Hazard: in the same cycle B writes addr 7 = 0x55 and A reads addr 7 → `a_rd_ready=0` that cycle. A is accepted the next cycle and returns 0x55 two cycles later. B's read of addr 3 in the hazard cycle is granted.
- Pipelined reads: A and B read addrs 0..7 continuously after preloading 0x10+addr → returns alternate A/B with no bubbles, each value correct at acceptance+2, never both data-valids high together.
- Reset mid-read: read accepted, then `rst=0` in the next cycle → no data-valid is ever asserted for that read.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-requester front end for a simple dual-port RAM clocked by clk.
// Writes and reads are arbitrated independently, with round-robin on each port.
module ram_arbiter #(
  parameter int WIDTH   = 8,
  parameter int ENTRIES = 256,
  localparam int AW     = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             a_wr_valid,
  input  logic [AW-1:0]    a_wr_addr,
  input  logic [WIDTH-1:0] a_wr_data,
  output logic             a_wr_ready,
  input  logic             b_wr_valid,
  input  logic [AW-1:0]    b_wr_addr,
  input  logic [WIDTH-1:0] b_wr_data,
  output logic             b_wr_ready,

  input  logic             a_rd_valid,
  input  logic [AW-1:0]    a_rd_addr,
  output logic             a_rd_ready,
  input  logic             b_rd_valid,
  input  logic [AW-1:0]    b_rd_addr,
  output logic             b_rd_ready,

  output logic [WIDTH-1:0] rd_data,
  output logic             a_rd_data_valid,
  output logic             b_rd_data_valid,

  output logic [AW-1:0]    ram_waddr,
  output logic [WIDTH-1:0] ram_write_data,
  output logic             ram_write_enable,
  output logic [AW-1:0]    ram_raddr,
  input  logic [WIDTH-1:0] ram_read_data
);

  // Handshake: a transfer happens in any cycle where valid && ready are both
  // high. Ready is combinational from valids/addresses and is 0 during reset.

  logic             wr_last_b_q, wr_last_b_d;
  logic             rd_last_b_q, rd_last_b_d;
  logic             ram_we_q, ram_we_d;
  logic [AW-1:0]    ram_waddr_q, ram_waddr_d;
  logic [WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic [AW-1:0]    ram_raddr_q, ram_raddr_d;
  logic [1:0]       hit_s1_q, hit_s1_d;
  logic [1:0]       hit_s2_q, hit_s2_d;

  logic             a_wr_gnt, b_wr_gnt;
  logic             a_rd_gnt, b_rd_gnt;
  logic             a_rd_elig, b_rd_elig;
  logic             wr_fire, rd_fire;
  logic [AW-1:0]    wr_addr_sel;
  logic [WIDTH-1:0] wr_data_sel;
  logic [AW-1:0]    rd_addr_sel;

  always_comb begin
    a_wr_gnt = 1'b0;
    b_wr_gnt = 1'b0;
    case ({a_wr_valid, b_wr_valid})
      2'b10:   a_wr_gnt = 1'b1;
      2'b01:   b_wr_gnt = 1'b1;
      2'b11: begin
        a_wr_gnt = wr_last_b_q;
        b_wr_gnt = !wr_last_b_q;
      end
      default: ;
    endcase
    a_wr_ready  = rst && a_wr_gnt;
    b_wr_ready  = rst && b_wr_gnt;
    wr_fire     = a_wr_ready || b_wr_ready;
    wr_addr_sel = b_wr_ready ? b_wr_addr : a_wr_addr;
    wr_data_sel = b_wr_ready ? b_wr_data : a_wr_data;
  end

  // A read racing a same-cycle write to its address would sample stale data
  // on the same edge the RAM commits, so it is held off one cycle.
  always_comb begin
    a_rd_elig = a_rd_valid && !(wr_fire && (wr_addr_sel == a_rd_addr));
    b_rd_elig = b_rd_valid && !(wr_fire && (wr_addr_sel == b_rd_addr));
    a_rd_gnt  = 1'b0;
    b_rd_gnt  = 1'b0;
    case ({a_rd_elig, b_rd_elig})
      2'b10:   a_rd_gnt = 1'b1;
      2'b01:   b_rd_gnt = 1'b1;
      2'b11: begin
        a_rd_gnt = rd_last_b_q;
        b_rd_gnt = !rd_last_b_q;
      end
      default: ;
    endcase
    a_rd_ready  = rst && a_rd_gnt;
    b_rd_ready  = rst && b_rd_gnt;
    rd_fire     = a_rd_ready || b_rd_ready;
    rd_addr_sel = b_rd_ready ? b_rd_addr : a_rd_addr;
  end

  always_comb begin
    wr_last_b_d = wr_last_b_q;
    rd_last_b_d = rd_last_b_q;
    ram_we_d    = wr_fire;
    ram_waddr_d = ram_waddr_q;
    ram_wdata_d = ram_wdata_q;
    ram_raddr_d = ram_raddr_q;
    hit_s1_d    = {a_rd_ready, b_rd_ready};
    hit_s2_d    = hit_s1_q;
    if (wr_fire) begin
      wr_last_b_d = b_wr_ready;
      ram_waddr_d = wr_addr_sel;
      ram_wdata_d = wr_data_sel;
    end
    if (rd_fire) begin
      rd_last_b_d = b_rd_ready;
      ram_raddr_d = rd_addr_sel;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_last_b_q <= 1'b1;
      rd_last_b_q <= 1'b1;
      ram_we_q    <= 1'b0;
      ram_waddr_q <= '0;
      ram_wdata_q <= '0;
      ram_raddr_q <= '0;
      hit_s1_q    <= 2'b00;
      hit_s2_q    <= 2'b00;
    end else begin
      wr_last_b_q <= wr_last_b_d;
      rd_last_b_q <= rd_last_b_d;
      ram_we_q    <= ram_we_d;
      ram_waddr_q <= ram_waddr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_raddr_q <= ram_raddr_d;
      hit_s1_q    <= hit_s1_d;
      hit_s2_q    <= hit_s2_d;
    end
  end

  assign ram_write_enable = ram_we_q;
  assign ram_waddr        = ram_waddr_q;
  assign ram_write_data   = ram_wdata_q;
  assign ram_raddr        = ram_raddr_q;
  assign rd_data          = ram_read_data;
  assign a_rd_data_valid  = hit_s2_q[1];
  assign b_rd_data_valid  = hit_s2_q[0];

endmodule
